display_scanner: RTL and testbench

Sequential front end for the seven-segment driver in the calculator datapath. Accepts a signed calculator result on a load handshake and converts its magnitude to BCD with a sequential double-dabble engine. Commits the digits to a double-buffered display register and time-multiplexes them onto the driver's digit-index/digit-value inputs at a fixed refresh rate. `a`, `x`, `isNeg` and `sel` connect directly to the seven-segment driver.

---
 rtl/disp_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/display_scanner.sv | 172 +++++++++++++++++
 tb/tb_display_scanner.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : disp_pkg
// Description : Shared definitions for the display_scanner slice. Holds the
//               conversion FSM encoding, the driver slot numbering, the
//               display range limits and the slot-to-digit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  // Conversion FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Driver slot numbering; the driver wiring is not in digit order
  localparam logic [1:0] SLOT_THOU = 2'd1;
  localparam logic [1:0] SLOT_HUND = 2'd0;
  localparam logic [1:0] SLOT_TENS = 2'd3;
  localparam logic [1:0] SLOT_ONES = 2'd2;

  // Largest displayable magnitudes
  localparam int unsigned MAX_POS = 9999;
  localparam int unsigned MAX_NEG = 99;

  // BCD shadow width: five digits cover any 16-bit magnitude
  localparam int BCD_W = 20;

  // Pick the BCD digit a given slot shows; digits packed {thou,hund,tens,ones}
  function automatic logic [3:0] slot_digit(input logic [15:0] digits,
                                            input logic [1:0]  slot);
    logic [3:0] d;
    case (slot)
      SLOT_THOU: d = digits[15:12];
      SLOT_HUND: d = digits[11:8];
      SLOT_TENS: d = digits[7:4];
      default:   d = digits[3:0];
    endcase
    return d;
  endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter. A start pulse loads the
//               binary operand; W add-3-then-shift iterations follow, one per
//               clock. o_done is high during the cycle whose edge performs the
//               final iteration, so o_bcd is complete on the following cycle.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_start       - load i_bin and begin conversion
//               i_bin[W]      - unsigned binary operand
//               o_done        - final iteration happens at the next edge
//               o_bcd[BCD_W]  - BCD shadow register
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int W     = 16,
  parameter int BCD_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [W-1:0]     i_bin,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd
);

  localparam int              CNT_W  = $clog2(W + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(W - 1);

  logic [W-1:0]     r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [BCD_W-1:0] w_adj;
  logic             w_last;

  // Add 3 to every digit >= 5 ahead of the shift
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_last = r_run && (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[W-1]};
      r_bin <= {r_bin[W-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_run <= 1'b0;
      end
    end
  end

  assign o_done = w_last;
  assign o_bcd  = r_bcd;

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : display_scanner
// Description : Front end for the seven-segment driver. Accepts a signed
//               result, converts its magnitude to BCD sequentially, commits
//               it to a display register and scans the four digit slots at
//               REFRESH_DIV cycles per slot.
// Config      : DISP_SAT_EN - when defined, out-of-range values are clamped
//               to 9999 / -99 before conversion; otherwise the low digits of
//               the magnitude are shown. ovf is reported in both builds.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               load           - request (accepted only while busy=0)
//               result[W]      - two's complement value to display
//               op_sel[3]      - operator code captured with result
//               busy           - conversion in progress
//               ovf            - last accepted value was out of range
//               a[2], x[4]     - slot index and its BCD digit
//               isNeg, sel[3]  - committed sign and operator
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
  import disp_pkg::*;
#(
  parameter int W           = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] result,
  input  logic [2:0]   op_sel,
  output logic         busy,
  output logic         ovf,
  output logic [1:0]   a,
  output logic [3:0]   x,
  output logic         isNeg,
  output logic [2:0]   sel
);

  localparam int               PRE_W      = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(REFRESH_DIV - 1);

  state_t           r_state;
  logic             r_neg_p;
  logic [2:0]       r_sel_p;
  logic             r_clamp_p;
  logic [15:0]      r_digits;
  logic             r_isNeg;
  logic [2:0]       r_sel;
  logic             r_ovf;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_a;
  logic [3:0]       r_x;

  logic             w_accept;
  logic             w_neg;
  logic [W-1:0]     w_mag;
  logic [W-1:0]     w_conv;
  logic             w_clamp;
  logic             w_done;
  logic [BCD_W-1:0] w_bcd;
  logic             w_range_ovf;
  logic [15:0]      w_digits_next;
  logic             w_wrap;
  logic [1:0]       w_a_next;

  assign w_accept = (r_state == ST_IDLE) && load;
  assign w_neg    = result[W-1];
  // Negating the most negative value wraps to itself, which read as
  // unsigned is exactly its magnitude
  assign w_mag    = w_neg ? (~result + 1'b1) : result;

`ifdef DISP_SAT_EN
  logic w_over;
  assign w_over  = w_neg ? (32'(w_mag) > MAX_NEG) : (32'(w_mag) > MAX_POS);
  assign w_clamp = w_over;
  assign w_conv  = w_over ? (w_neg ? W'(MAX_NEG) : W'(MAX_POS)) : w_mag;
`else
  assign w_clamp = 1'b0;
  assign w_conv  = w_mag;
`endif

  bin2bcd_seq #(
    .W     (W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept),
    .i_bin   (w_conv),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Range check on the converted digits; a clamped value is already in
  // range, so its overflow is carried by the capture-time flag instead
  assign w_range_ovf = r_neg_p ? (|w_bcd[BCD_W-1:8]) : (|w_bcd[BCD_W-1:16]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_neg_p   <= 1'b0;
      r_sel_p   <= '0;
      r_clamp_p <= 1'b0;
      r_digits  <= '0;
      r_isNeg   <= 1'b0;
      r_sel     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            // Zero has a clear sign bit, so it is always positive
            r_neg_p   <= w_neg;
            r_sel_p   <= op_sel;
            r_clamp_p <= w_clamp;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_done) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_digits <= w_digits_next;
          r_isNeg  <= r_neg_p;
          r_sel    <= r_sel_p;
          r_ovf    <= r_clamp_p | w_range_ovf;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Digits the display register will hold after this edge. Negative values
  // blank the upper two slots, which the driver uses for the minus sign.
  always_comb begin
    w_digits_next = r_digits;
    if (r_state == ST_COMMIT) begin
      w_digits_next = r_neg_p ? {8'h00, w_bcd[7:0]} : w_bcd[15:0];
    end
  end

  assign w_wrap   = (r_pre == c_pre_last);
  assign w_a_next = w_wrap ? (r_a + 2'd1) : r_a;

  // x is looked up from next-state slot and next-state display so that a
  // commit landing on a slot change never shows a stale digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_a   <= '0;
      r_x   <= '0;
    end else begin
      r_pre <= w_wrap ? '0 : (r_pre + 1'b1);
      r_a   <= w_a_next;
      r_x   <= slot_digit(w_digits_next, w_a_next);
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign ovf   = r_ovf;
  assign a     = r_a;
  assign x     = r_x;
  assign isNeg = r_isNeg;
  assign sel   = r_sel;

endmodule : display_scanner
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_display_scanner
// Description : Directed self-checking bench for display_scanner with
//               REFRESH_DIV=4. Expected frames are packed by slot index:
//               frame[4*slot +: 4] is the digit shown on slot a=slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] result = '0;
  logic [2:0]  op_sel = '0;
  logic        busy;
  logic        ovf;
  logic [1:0]  a;
  logic [3:0]  x;
  logic        isNeg;
  logic [2:0]  sel;

  int checks = 0;
  int errors = 0;

  display_scanner #(
    .W           (16),
    .REFRESH_DIV (RD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .result (result),
    .op_sel (op_sel),
    .busy   (busy),
    .ovf    (ovf),
    .a      (a),
    .x      (x),
    .isNeg  (isNeg),
    .sel    (sel)
  );

  always #5 clk = ~clk;

  // Pulse load across one rising edge; returns on the falling edge after it
  task automatic do_load(input logic [15:0] v, input logic [2:0] op);
    @(negedge clk);
    load   = 1'b1;
    result = v;
    op_sel = op;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Count falling edges on which busy reads 1 (bounded)
  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Record one full frame; unvisited slots keep F
  task automatic capture_frame(output logic [15:0] f);
    f = 16'hFFFF;
    repeat (4 * RD) begin
      f[{a, 2'b00} +: 4] = x;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ovf, a, x, isNeg, sel} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero", {busy, ovf, a, x, isNeg, sel});
    end
    rst = 1'b0;
    for (int k = 0; k < 4 * RD; k++) begin
      checks++;
      if (a !== 2'(k / RD) || x !== 4'd0 || busy !== 1'b0 || ovf !== 1'b0 ||
          isNeg !== 1'b0 || sel !== 3'd0) begin
        errors++;
        $display("FAIL reset_scan[%0d]: a=%0d x=%0d busy=%b ovf=%b neg=%b sel=%0d want a=%0d rest 0",
                 k, a, x, busy, ovf, isNeg, sel, k / RD);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_pos;
    int n;
    logic [15:0] f;
    do_load(16'd1234, 3'd0);
    busy_len(n);
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL busy_len_1234: got %0d want 17", n);
    end
    capture_frame(f);
    checks++;
    if (f !== 16'h3412 || isNeg !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL disp_1234: frame=%h neg=%b ovf=%b want 3412 0 0", f, isNeg, ovf);
    end
  endtask

  task automatic test_negative;
    int n;
    logic [15:0] f;
    do_load(16'hFFD6, 3'd3);  // -42
    busy_len(n);
    capture_frame(f);
    checks++;
    if (f !== 16'h4200 || isNeg !== 1'b1 || sel !== 3'd3 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL disp_m42: frame=%h neg=%b sel=%0d ovf=%b want 4200 1 3 0", f, isNeg, sel, ovf);
    end
  endtask

  task automatic test_overflow;
    int n;
    logic [15:0] f;
    logic [15:0] exp_big, exp_min, exp_m100;
`ifdef DISP_SAT_EN
    exp_big  = 16'h9999;
    exp_min  = 16'h9900;
    exp_m100 = 16'h9900;
`else
    exp_big  = 16'h4523;  // 2345
    exp_min  = 16'h6800;  // 32768 mod 100
    exp_m100 = 16'h0000;  // 100 mod 100
`endif
    do_load(16'd12345, 3'd1);
    busy_len(n);
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL busy_len_12345: got %0d want 17", n);
    end
    capture_frame(f);
    checks++;
    if (f !== exp_big || ovf !== 1'b1 || isNeg !== 1'b0) begin
      errors++;
      $display("FAIL disp_12345: frame=%h ovf=%b neg=%b want %h 1 0", f, ovf, isNeg, exp_big);
    end
    do_load(16'h8000, 3'd5);  // -32768
    busy_len(n);
    capture_frame(f);
    checks++;
    if (f !== exp_min || ovf !== 1'b1 || isNeg !== 1'b1 || sel !== 3'd5) begin
      errors++;
      $display("FAIL disp_m32768: frame=%h ovf=%b neg=%b sel=%0d want %h 1 1 5", f, ovf, isNeg, sel, exp_min);
    end
    do_load(16'hFF9C, 3'd0);  // -100
    busy_len(n);
    capture_frame(f);
    checks++;
    if (f !== exp_m100 || ovf !== 1'b1 || isNeg !== 1'b1) begin
      errors++;
      $display("FAIL disp_m100: frame=%h ovf=%b neg=%b want %h 1 1", f, ovf, isNeg, exp_m100);
    end
  endtask

  task automatic test_boundaries;
    int n;
    logic [15:0] f;
    do_load(16'hFF9D, 3'd6);  // -99
    busy_len(n);
    capture_frame(f);
    checks++;
    if (f !== 16'h9900 || ovf !== 1'b0 || isNeg !== 1'b1) begin
      errors++;
      $display("FAIL disp_m99: frame=%h ovf=%b neg=%b want 9900 0 1", f, ovf, isNeg);
    end
    do_load(16'd0, 3'd7);
    busy_len(n);
    capture_frame(f);
    checks++;
    if (f !== 16'h0000 || ovf !== 1'b0 || isNeg !== 1'b0 || sel !== 3'd7) begin
      errors++;
      $display("FAIL disp_zero: frame=%h ovf=%b neg=%b sel=%0d want 0000 0 0 7", f, ovf, isNeg, sel);
    end
  endtask

  task automatic test_ignored_load;
    int n;
    logic [15:0] f;
    do_load(16'd77, 3'd2);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        load   = 1'b1;
        result = 16'd500;
        op_sel = 3'd4;
      end else if (n == 6) begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL busy_len_77: got %0d want 17", n);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queue: busy=%b want 0", busy);
    end
    capture_frame(f);
    checks++;
    if (f !== 16'h7700 || sel !== 3'd2) begin
      errors++;
      $display("FAIL disp_77: frame=%h sel=%0d want 7700 2", f, sel);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [15:0] f;
    do_load(16'd5, 3'd1);
    busy_len(n);
    load   = 1'b1;
    result = 16'd9999;
    op_sel = 3'd2;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    busy_len(n);
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL busy_len_9999: got %0d want 17", n);
    end
    capture_frame(f);
    checks++;
    if (f !== 16'h9999 || ovf !== 1'b0 || sel !== 3'd2 || isNeg !== 1'b0) begin
      errors++;
      $display("FAIL disp_9999: frame=%h ovf=%b sel=%0d neg=%b want 9999 0 2 0", f, ovf, sel, isNeg);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] f;
    // Leave a negative value committed so the reset has flags to clear
    do_load(16'hFFD6, 3'd3);
    begin
      int n;
      busy_len(n);
    end
    do_load(16'd8888, 3'd4);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, ovf, a, x, isNeg, sel} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async: got %b want all zero", {busy, ovf, a, x, isNeg, sel});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b want 0", busy);
    end
    capture_frame(f);
    checks++;
    if (f !== 16'h0000 || isNeg !== 1'b0 || sel !== 3'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_disp: frame=%h neg=%b sel=%0d ovf=%b want 0000 0 0 0", f, isNeg, sel, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_load_pos();
    test_negative();
    test_overflow();
    test_boundaries();
    test_ignored_load();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_display_scanner
`default_nettype wire
